// File: rtl/rob_unit.sv
// rtl/rob_unit.sv - reorder buffer: in-order allocate, out-of-order complete, in-order retire
// A mispredicted retire clears the buffer at once and raises a one-cycle flush after it.
module rob_unit #(
  parameter int NUM_ROB_ENTS = 64,
  parameter int NUM_FUS      = 4,
  parameter int NUM_AREGS    = 32,
  parameter int NUM_PREGS    = 128
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    disp_valid,
  output logic                                    disp_ready,
  input  logic [$clog2(NUM_AREGS)-1:0]            disp_areg,
  input  logic [$clog2(NUM_PREGS)-1:0]            disp_preg,
  input  logic [$clog2(NUM_PREGS)-1:0]            disp_old_preg,
  input  logic                                    disp_has_dst,
  output logic [$clog2(NUM_ROB_ENTS)-1:0]         disp_rob_index,
  input  logic [NUM_FUS-1:0]                      wb_valid,
  input  logic [NUM_FUS*$clog2(NUM_ROB_ENTS)-1:0] wb_rob_index,
  input  logic [NUM_FUS-1:0]                      wb_br_mispred,
  output logic                                    ret_valid,
  output logic [$clog2(NUM_AREGS)-1:0]            ret_areg,
  output logic [$clog2(NUM_PREGS)-1:0]            ret_preg,
  output logic [$clog2(NUM_PREGS)-1:0]            ret_free_preg,
  output logic                                    ret_has_dst,
  output logic                                    flush,
  output logic [$clog2(NUM_ROB_ENTS):0]           rob_count
);

  localparam int IW = $clog2(NUM_ROB_ENTS);
  localparam int AW = $clog2(NUM_AREGS);
  localparam int PW = $clog2(NUM_PREGS);

  logic [IW:0]             head, tail;
  logic [NUM_ROB_ENTS-1:0] valid, complete, mispred;
  logic [NUM_ROB_ENTS-1:0] has_dst_q;
  logic [AW-1:0]           areg_q     [NUM_ROB_ENTS];
  logic [PW-1:0]           preg_q     [NUM_ROB_ENTS];
  logic [PW-1:0]           old_preg_q [NUM_ROB_ENTS];

  logic [IW-1:0]           head_idx, tail_idx;
  logic                    full, disp_fire, ret_mispred;
  logic [NUM_ROB_ENTS-1:0] disp_vec, ret_vec, wb_hit, wb_mis;

  assign head_idx       = head[IW-1:0];
  assign tail_idx       = tail[IW-1:0];
  assign rob_count      = tail - head;
  assign full           = (rob_count == (IW+1)'(NUM_ROB_ENTS));
  assign disp_ready     = !full && !flush;
  assign disp_fire      = disp_valid && disp_ready;
  assign disp_rob_index = tail_idx;

  assign ret_valid      = valid[head_idx] && complete[head_idx] && !flush;
  assign ret_mispred    = ret_valid && mispred[head_idx];
  assign ret_areg       = areg_q[head_idx];
  assign ret_preg       = preg_q[head_idx];
  assign ret_free_preg  = old_preg_q[head_idx];
  assign ret_has_dst    = has_dst_q[head_idx];

  assign disp_vec = disp_fire ? (NUM_ROB_ENTS'(1) << tail_idx) : '0;
  assign ret_vec  = ret_valid ? (NUM_ROB_ENTS'(1) << head_idx) : '0;

  // Ports hitting the same entry OR-merge; invalid targets are masked below.
  always_comb begin
    wb_hit = '0;
    wb_mis = '0;
    for (int p = 0; p < NUM_FUS; p++) begin
      if (wb_valid[p]) begin
        wb_hit[wb_rob_index[p*IW +: IW]] = 1'b1;
        if (wb_br_mispred[p]) wb_mis[wb_rob_index[p*IW +: IW]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      complete <= '0;
      mispred  <= '0;
      head     <= '0;
      tail     <= '0;
      flush    <= 1'b0;
    end else if (flush || ret_mispred) begin
      // Pointers collapse at the mispredicted retire; the flush cycle then holds everything off.
      valid    <= '0;
      complete <= '0;
      mispred  <= '0;
      head     <= '0;
      tail     <= '0;
      flush    <= ret_mispred;
    end else begin
      valid    <= (valid | disp_vec) & ~ret_vec;
      complete <= (complete | (wb_hit & valid)) & ~disp_vec & ~ret_vec;
      mispred  <= (mispred | (wb_mis & valid)) & ~disp_vec & ~ret_vec;
      if (disp_fire) tail <= tail + 1'b1;
      if (ret_valid) head <= head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (disp_fire) begin
      areg_q[tail_idx]     <= disp_areg;
      preg_q[tail_idx]     <= disp_preg;
      old_preg_q[tail_idx] <= disp_old_preg;
      has_dst_q[tail_idx]  <= disp_has_dst;
    end
  end

endmodule

// File: tb/tb_rob_unit.sv
// tb/tb_rob_unit.sv - directed self-checking bench for rob_unit
module tb_rob_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_areg;
  logic [6:0]  disp_preg;
  logic [6:0]  disp_old_preg;
  logic        disp_has_dst;
  logic [5:0]  disp_rob_index;
  logic [3:0]  wb_valid;
  logic [23:0] wb_rob_index;
  logic [3:0]  wb_br_mispred;
  logic        ret_valid;
  logic [4:0]  ret_areg;
  logic [6:0]  ret_preg;
  logic [6:0]  ret_free_preg;
  logic        ret_has_dst;
  logic        flush;
  logic [6:0]  rob_count;

  int checks = 0;
  int errors = 0;

  rob_unit dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_areg(disp_areg),
    .disp_preg(disp_preg), .disp_old_preg(disp_old_preg), .disp_has_dst(disp_has_dst),
    .disp_rob_index(disp_rob_index),
    .wb_valid(wb_valid), .wb_rob_index(wb_rob_index), .wb_br_mispred(wb_br_mispred),
    .ret_valid(ret_valid), .ret_areg(ret_areg), .ret_preg(ret_preg),
    .ret_free_preg(ret_free_preg), .ret_has_dst(ret_has_dst),
    .flush(flush), .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    disp_valid    = 1'b0;
    disp_areg     = '0;
    disp_preg     = '0;
    disp_old_preg = '0;
    disp_has_dst  = 1'b0;
    wb_valid      = '0;
    wb_rob_index  = '0;
    wb_br_mispred = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic disp(input int areg, input int preg, input int old_preg);
    disp_valid    = 1'b1;
    disp_areg     = 5'(areg);
    disp_preg     = 7'(preg);
    disp_old_preg = 7'(old_preg);
    disp_has_dst  = 1'b1;
  endtask

  task automatic wb(input int port, input int idx, input bit mis);
    wb_valid[port]           = 1'b1;
    wb_rob_index[port*6 +: 6] = 6'(idx);
    wb_br_mispred[port]      = mis;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("reset_ret_valid", ret_valid, 0);
    chk("reset_count", rob_count, 0);
    chk("reset_disp_ready", disp_ready, 1);
    chk("reset_disp_index", disp_rob_index, 0);
    chk("reset_flush", flush, 0);

    // 1: three dispatches
    for (int i = 0; i < 3; i++) begin
      disp(i + 1, 40 + i, 60 + i);
      chk("t1_disp_index", disp_rob_index, i);
      tick();
      chk("t1_ret_valid", ret_valid, 0);
    end
    chk("t1_count", rob_count, 3);

    // 2: writebacks out of order, retire in order
    wb(0, 2, 0); tick();
    chk("t2_no_ret_after_wb2", ret_valid, 0);
    wb(0, 0, 0); tick();
    chk("t2_ret0_valid", ret_valid, 1);
    chk("t2_ret0_preg", ret_preg, 40);
    chk("t2_ret0_areg", ret_areg, 1);
    chk("t2_ret0_free", ret_free_preg, 60);
    chk("t2_ret0_has_dst", ret_has_dst, 1);
    wb(1, 1, 0); tick();
    chk("t2_ret1_valid", ret_valid, 1);
    chk("t2_ret1_preg", ret_preg, 41);
    chk("t2_count_2", rob_count, 2);
    tick();
    chk("t2_ret2_valid", ret_valid, 1);
    chk("t2_ret2_preg", ret_preg, 42);
    chk("t2_count_1", rob_count, 1);
    tick();
    chk("t2_empty_ret", ret_valid, 0);
    chk("t2_empty_count", rob_count, 0);

    // 3: fill to 64, retire one, wrap
    do_reset();
    for (int i = 0; i < 64; i++) begin
      chk("t3_ready_fill", disp_ready, 1);
      disp(i % 32, i, i + 64);
      tick();
    end
    chk("t3_full_count", rob_count, 64);
    chk("t3_full_ready", disp_ready, 0);
    wb(3, 0, 0); tick();
    chk("t3_ret_valid", ret_valid, 1);
    chk("t3_ret_preg", ret_preg, 0);
    chk("t3_ready_same_cycle", disp_ready, 0);
    disp(7, 99, 98); tick();
    chk("t3_count_after_ret", rob_count, 63);
    chk("t3_ready_after_ret", disp_ready, 1);
    chk("t3_wrap_index", disp_rob_index, 0);
    disp(8, 100, 101); tick();
    chk("t3_refull_count", rob_count, 64);
    chk("t3_refull_ready", disp_ready, 0);

    // 4: mispredict on idx1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      disp(i, 10 + i, 20 + i);
      tick();
    end
    wb(0, 1, 1); tick();
    chk("t4_no_ret", ret_valid, 0);
    wb(0, 0, 0); tick();
    chk("t4_ret0_valid", ret_valid, 1);
    chk("t4_ret0_preg", ret_preg, 10);
    wb(0, 2, 0); wb(1, 3, 0); wb(2, 4, 0); tick();
    chk("t4_ret1_valid", ret_valid, 1);
    chk("t4_ret1_preg", ret_preg, 11);
    chk("t4_pre_flush", flush, 0);
    chk("t4_count_4", rob_count, 4);
    disp(9, 90, 91); tick();
    chk("t4_flush", flush, 1);
    chk("t4_flush_count", rob_count, 0);
    chk("t4_flush_ret", ret_valid, 0);
    chk("t4_flush_ready", disp_ready, 0);
    disp(9, 92, 93); wb(0, 2, 0); tick();
    chk("t4_flush_done", flush, 0);
    chk("t4_after_count", rob_count, 0);
    chk("t4_after_ready", disp_ready, 1);
    chk("t4_after_ret", ret_valid, 0);
    chk("t4_after_index", disp_rob_index, 0);

    // 5: four ports at once plus a dispatch, then duplicate-index pair
    do_reset();
    for (int i = 0; i < 4; i++) begin
      disp(i, 20 + i, 30 + i);
      tick();
    end
    for (int p = 0; p < 4; p++) wb(p, p, 0);
    disp(4, 24, 34);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t5_count", rob_count, 5 - i);
      chk("t5_ret_valid", ret_valid, 1);
      chk("t5_ret_preg", ret_preg, 20 + i);
      tick();
    end
    chk("t5_count_1", rob_count, 1);
    chk("t5_idle", ret_valid, 0);
    wb(0, 4, 0); wb(1, 4, 1); tick();
    chk("t5_dup_ret", ret_valid, 1);
    chk("t5_dup_preg", ret_preg, 24);
    tick();
    chk("t5_dup_merge_flush", flush, 1);
    chk("t5_dup_count", rob_count, 0);
    tick();

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) begin
      disp(i, 50 + i, 70 + i);
      tick();
    end
    wb(0, 0, 0); tick();
    chk("t6_pre_count", rob_count, 10);
    chk("t6_pre_ret", ret_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", rob_count, 0);
    chk("t6_async_ret", ret_valid, 0);
    chk("t6_async_index", disp_rob_index, 0);
    chk("t6_async_ready", disp_ready, 1);
    tick();
    rst_n = 1'b1;
    chk("t6_post_count", rob_count, 0);
    chk("t6_post_ready", disp_ready, 1);
    disp(3, 5, 6);
    chk("t6_first_index", disp_rob_index, 0);
    tick();
    chk("t6_first_count", rob_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_unit.md
Name: rob_unit

Overview:
Reorder buffer for the out-of-order core. It sits downstream of rename/dispatch and consumes execute-stage completions, one writeback port per functional unit. Entries are allocated in program order and marked complete out of order. Entries retire in order, one per cycle, giving the retiring destination mapping and the old physical register to free. A branch mispredict is resolved at retire with a full-buffer flush.

Parameters:
NUM_ROB_ENTS, 64, entry count; power of 2
NUM_FUS, 4, number of writeback ports
NUM_AREGS, 32, architectural registers
NUM_PREGS, 128, physical registers

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
disp_valid  in  1  dispatch request
disp_ready  out  1  entry available; combinational from state
disp_areg  in  log2(NUM_AREGS)  destination architectural register
disp_preg  in  log2(NUM_PREGS)  newly allocated physical register
disp_old_preg  in  log2(NUM_PREGS)  previous mapping of disp_areg
disp_has_dst  in  1  instruction writes a register
disp_rob_index  out  log2(NUM_ROB_ENTS)  tail index given to the dispatching op
wb_valid  in  NUM_FUS  per-port completion strobe
wb_rob_index  in  NUM_FUS*log2(NUM_ROB_ENTS)  per-port completed entry index
wb_br_mispred  in  NUM_FUS  per-port branch mispredict flag
ret_valid  out  1  head entry retires this cycle
ret_areg  out  log2(NUM_AREGS)  retiring destination architectural register
ret_preg  out  log2(NUM_PREGS)  retiring physical register
ret_free_preg  out  log2(NUM_PREGS)  physical register to return to the free list
ret_has_dst  out  1  retiring op writes a register
flush  out  1  one-cycle pipeline flush pulse
rob_count  out  log2(NUM_ROB_ENTS)+1  occupied entries

Behaviour:
- Pointers: head and tail are log2(N)+1 bits, with the MSB as the wrap bit.
- Occupancy: rob_count = tail - head, modulo 2N. Full when rob_count == N; empty when head == tail.
- Per-entry state: valid, complete, mispred, areg, preg, old_preg, has_dst.
- Reset (asynchronous, rst_n=0): all valid, complete and mispred bits are cleared; head=tail=0; flush=0. Resulting outputs: ret_valid=0, rob_count=0, disp_ready=1, disp_rob_index=0.
- Dispatch:
  - disp_ready = !full && !flush.
  - On disp_valid && disp_ready, the entry at tail[log2N-1:0] is written with valid=1, complete=0, mispred=0 and the payload; tail increments.
  - disp_rob_index = tail low bits.
  - There is no same-cycle bypass: when full, a retire in the same cycle does not raise disp_ready until the next cycle.
- Writeback:
  - For each port p with wb_valid[p] and a valid target entry: set complete=1 and OR wb_br_mispred[p] into mispred.
  - Writebacks to invalid entries are ignored.
  - Several ports hitting the same index in one cycle are legal; their results are OR-merged.
- Retire:
  - ret_valid = head entry valid && complete && !flush, combinational. ret_* fields come from the head entry.
  - When ret_valid is high, the head entry is cleared and head increments.
  - Latency: a writeback in cycle N makes ret_valid possible in cycle N+1 at the earliest. A dispatch in cycle N can therefore retire in cycle N+2 at the earliest.
- Mispredict:
  - When the retiring entry has mispred=1, it retires normally in that cycle and a flush is registered.
  - In the next cycle flush=1 for exactly one cycle. In that cycle: all valid bits are cleared, head=tail=0, disp_ready=0, ret_valid=0, and all writebacks are ignored.
  - Normal operation resumes the cycle after the flush.
  - A dispatch accepted in the same cycle as the mispredicted retire is discarded by the flush.
- Simultaneous events: dispatch, up to NUM_FUS writebacks and one retire can all occur in the same cycle.
  - rob_count changes by +1 for a dispatch and -1 for a retire.
  - A writeback to the current head in the same cycle does not retire that entry in that cycle.
- Wrap-around: both pointers wrap naturally from index N-1 to 0, with the wrap bit toggling.

Test Plan:
1. Reset, then dispatch 3 ops (areg 1/2/3, preg 40/41/42) -> disp_rob_index 0,1,2; rob_count=3; ret_valid=0 throughout.
2. From (1), write back idx2, then idx0, then idx1 on separate cycles -> retire order 0,1,2 with ret_preg 40,41,42; idx0 retires the cycle after its writeback; rob_count returns to 0.
3. Dispatch 64 ops with no writebacks -> disp_ready=0 at rob_count=64. Write back idx0 -> it retires and disp_ready=1 the following cycle. The next dispatch gets index 0 (wrap).
4. Dispatch 5 ops; write back idx1 with wb_br_mispred=1, then idx0,2,3,4 -> idx0 and idx1 retire, flush=1 for one cycle, rob_count=0, and idx2-4 never retire.
5. With 4 entries outstanding: all 4 ports write back idx0-3 while a dispatch is accepted in the same cycle -> idx0-3 retire on consecutive cycles and rob_count goes 5,4,3,2,1. A duplicate-index writeback pair is accepted without error.
6. Assert rst_n=0 mid-stream with 10 entries outstanding -> outputs clear immediately, without waiting for a clk edge; after release, rob_count=0, disp_ready=1 and the first dispatch gets index 0.
